// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for a 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to add stallCount/flushCount event counters.
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int FWD_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ID,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             usesRt_ID,
    input  logic [REG_W-1:0] rd_ID,
    input  logic             regWrite_ID,
    input  logic             memRead_ID,
    input  logic             flush,
    output logic [FWD_W-1:0] forwardA,
    output logic [FWD_W-1:0] forwardB,
    output logic             stall,
    output logic             bubble
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stallCount,
    output logic [31:0]      flushCount
`endif
);

    localparam logic [FWD_W-1:0] SEL_RF  = FWD_W'(0);
    localparam logic [FWD_W-1:0] SEL_WB  = FWD_W'(1);
    localparam logic [FWD_W-1:0] SEL_MEM = FWD_W'(2);

    logic [REG_W-1:0] rdEx;
    logic             regWriteEx;
    logic             memReadEx;
    logic [REG_W-1:0] rdMem;
    logic             regWriteMem;

    logic             loadUse;
    logic             inject;
    logic             exWritesReg;
    logic             memWritesReg;
    logic             hitExA;
    logic             hitExB;
    logic             hitMemA;
    logic             hitMemB;
    logic [FWD_W-1:0] nextFwdA;
    logic [FWD_W-1:0] nextFwdB;

    assign exWritesReg  = regWriteEx && (rdEx != '0);
    assign memWritesReg = regWriteMem && (rdMem != '0);

    assign hitExA  = exWritesReg && (rdEx == rs_ID);
    assign hitExB  = exWritesReg && (rdEx == rt_ID) && usesRt_ID;
    assign hitMemA = memWritesReg && (rdMem == rs_ID);
    assign hitMemB = memWritesReg && (rdMem == rt_ID) && usesRt_ID;

    assign loadUse = valid_ID && memReadEx && (rdEx != '0) &&
                     ((rdEx == rs_ID) ||
                      (usesRt_ID && (rdEx == rt_ID)));

    assign inject = flush || loadUse || !valid_ID;
    assign stall  = loadUse && !flush;
    assign bubble = stall || flush;

    // EX producer will sit in MEM next cycle, MEM producer in WB.
    always_comb begin
        nextFwdA = SEL_RF;
        priority case (1'b1)
            inject:  nextFwdA = SEL_RF;
            hitExA:  nextFwdA = SEL_MEM;
            hitMemA: nextFwdA = SEL_WB;
            default: nextFwdA = SEL_RF;
        endcase
    end

    always_comb begin
        nextFwdB = SEL_RF;
        priority case (1'b1)
            inject:  nextFwdB = SEL_RF;
            hitExB:  nextFwdB = SEL_MEM;
            hitMemB: nextFwdB = SEL_WB;
            default: nextFwdB = SEL_RF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdEx        <= '0;
            regWriteEx  <= 1'b0;
            memReadEx   <= 1'b0;
            rdMem       <= '0;
            regWriteMem <= 1'b0;
            forwardA    <= SEL_RF;
            forwardB    <= SEL_RF;
        end else begin
            rdMem       <= rdEx;
            regWriteMem <= regWriteEx;
            if (inject) begin
                rdEx       <= '0;
                regWriteEx <= 1'b0;
                memReadEx  <= 1'b0;
            end else begin
                rdEx       <= rd_ID;
                regWriteEx <= regWrite_ID;
                memReadEx  <= memRead_ID;
            end
            forwardA <= nextFwdA;
            forwardB <= nextFwdB;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall) stallCount <= stallCount + 32'd1;
            if (flush) flushCount <= flushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit.
// Define HAZ_PERF_CNT_EN to also check the event counters.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst;
    logic       valid_ID;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic       usesRt_ID;
    logic [4:0] rd_ID;
    logic       regWrite_ID;
    logic       memRead_ID;
    logic       flush;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stall;
    logic       bubble;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;
`endif

    int nTests = 0;
    int nFail  = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .valid_ID    (valid_ID),
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .usesRt_ID   (usesRt_ID),
        .rd_ID       (rd_ID),
        .regWrite_ID (regWrite_ID),
        .memRead_ID  (memRead_ID),
        .flush       (flush),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .stall       (stall),
        .bubble      (bubble)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stallCount  (stallCount),
        .flushCount  (flushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic fl);
        valid_ID    = v;
        rs_ID       = rs;
        rt_ID       = rt;
        usesRt_ID   = ur;
        rd_ID       = rd;
        regWrite_ID = rw;
        memRead_ID  = mr;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // A load sitting in MEM must never be the source of a MEM forward.
    logic ldIss, ldEx, ldMem;
    always @(negedge clk) begin
        ldIss = rst && valid_ID && memRead_ID && !flush && !stall;
        if (rst && ldMem) begin
            chk("ldMemFwdA", 32'(forwardA == 2'b10), 32'd0);
            chk("ldMemFwdB", 32'(forwardB == 2'b10), 32'd0);
        end
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ldEx  <= 1'b0;
            ldMem <= 1'b0;
        end else begin
            ldEx  <= ldIss;
            ldMem <= ldEx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ldIss = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rstFwdA", 32'(forwardA), 32'd0);
        chk("rstFwdB", 32'(forwardB), 32'd0);
        chk("rstStall", 32'(stall), 32'd0);
        chk("rstBubble", 32'(bubble), 32'd0);
        rst = 1'b1;
        tick();

        // add r3,r1,r2 ; sub r5,r3,r4
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 4, 1, 5, 1, 0, 0);
        #1 chk("t1Stall", 32'(stall), 32'd0);
        tick();
        chk("t1FwdA", 32'(forwardA), 32'd2);
        chk("t1FwdB", 32'(forwardB), 32'd0);

        // add r3 ; add r3,r3,r1 ; xor r8,r3,r3 -> youngest wins
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 3, 1, 8, 1, 0, 0);
        tick();
        chk("prioFwdA", 32'(forwardA), 32'd2);
        chk("prioFwdB", 32'(forwardB), 32'd2);

        // add r3 ; nop ; or r6,r7,r3
        drive(1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        idle();
        tick();
        drive(1, 7, 3, 1, 6, 1, 0, 0);
        tick();
        chk("t2FwdA", 32'(forwardA), 32'd0);
        chk("t2FwdB", 32'(forwardB), 32'd1);

        // lw r3 ; addi r10,r1 (rt field 3 not read)
        drive(1, 1, 3, 0, 3, 1, 1, 0);
        tick();
        drive(1, 1, 3, 0, 10, 1, 0, 0);
        #1 chk("noRtStall", 32'(stall), 32'd0);
        tick();
        chk("noRtFwdA", 32'(forwardA), 32'd0);
        chk("noRtFwdB", 32'(forwardB), 32'd0);

        // lw r4,0(r1) ; add r6,r4,r2
        drive(1, 1, 4, 0, 4, 1, 1, 0);
        tick();
        drive(1, 4, 2, 1, 6, 1, 0, 0);
        #1 chk("t3Stall", 32'(stall), 32'd1);
        chk("t3Bubble", 32'(bubble), 32'd1);
        tick();
        chk("t3Stall2", 32'(stall), 32'd0);
        chk("t3Bubble2", 32'(bubble), 32'd0);
        chk("t3FwdBub", 32'(forwardA), 32'd0);
        tick();
        chk("t3FwdA", 32'(forwardA), 32'd1);
        chk("t3FwdB", 32'(forwardB), 32'd0);

        // add r0,r1,r2 ; sub r5,r0,r0
        drive(1, 1, 2, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 5, 1, 0, 0);
        tick();
        chk("t4FwdA", 32'(forwardA), 32'd0);
        chk("t4FwdB", 32'(forwardB), 32'd0);

        // lw r4 in EX, beq r4,r4 in ID flushed
        drive(1, 1, 4, 0, 4, 1, 1, 0);
        tick();
        drive(1, 4, 4, 1, 0, 0, 0, 1);
        #1 chk("t5Stall", 32'(stall), 32'd0);
        chk("t5Bubble", 32'(bubble), 32'd1);
        tick();
        chk("t5FwdInj", 32'(forwardA), 32'd0);
        drive(1, 4, 4, 1, 7, 1, 0, 0);
        #1 chk("t5Stall2", 32'(stall), 32'd0);
        tick();
        chk("t5FwdA", 32'(forwardA), 32'd1);
        chk("t5FwdB", 32'(forwardB), 32'd1);

        // flushed lw r9 must leave no trace
        drive(1, 1, 0, 0, 9, 1, 1, 1);
        #1 chk("flBubble", 32'(bubble), 32'd1);
        chk("flStall", 32'(stall), 32'd0);
        tick();
        drive(1, 9, 9, 1, 2, 1, 0, 0);
        #1 chk("flStall2", 32'(stall), 32'd0);
        tick();
        chk("flFwdA", 32'(forwardA), 32'd0);
        chk("flFwdB", 32'(forwardB), 32'd0);

        // lw r4 ; lw r4,0(r4) ; add r5,r4,r0
        drive(1, 1, 4, 0, 4, 1, 1, 0);
        tick();
        drive(1, 4, 4, 0, 4, 1, 1, 0);
        #1 chk("b2bStallA", 32'(stall), 32'd1);
        tick();
        chk("b2bRelA", 32'(stall), 32'd0);
        tick();
        drive(1, 4, 0, 1, 5, 1, 0, 0);
        #1 chk("b2bStallB", 32'(stall), 32'd1);
        tick();
        chk("b2bRelB", 32'(stall), 32'd0);
        tick();
        chk("b2bFwdA", 32'(forwardA), 32'd1);
        chk("b2bFwdB", 32'(forwardB), 32'd0);

        // add r1 ; lw r4,0(r1) ; add r6,r4,r2 then reset mid-stall
        drive(1, 2, 3, 1, 1, 1, 0, 0);
        tick();
        drive(1, 1, 4, 0, 4, 1, 1, 0);
        tick();
        chk("t6FwdA", 32'(forwardA), 32'd2);
        drive(1, 4, 2, 1, 6, 1, 0, 0);
        #1 chk("t6Stall", 32'(stall), 32'd1);
`ifdef HAZ_PERF_CNT_EN
        chk("stallCnt", stallCount, 32'd3);
        chk("flushCnt", flushCount, 32'd2);
`endif
        rst = 1'b0;
        #1;
        chk("t6RstStall", 32'(stall), 32'd0);
        chk("t6RstBubble", 32'(bubble), 32'd0);
        chk("t6RstFwdA", 32'(forwardA), 32'd0);
        chk("t6RstFwdB", 32'(forwardB), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("t6RstCnt", stallCount, 32'd0);
`endif
        idle();
        tick();
        rst = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the execute stage's forwarding muxes.
- Keeps its own shadow pipeline of destination tags (EX/MEM/WB) and drives registered forwardA/forwardB selects into the execute stage.
- Detects load-use hazards and requests a one-cycle stall plus bubble.
- Sits between decode and execute; the decode stage feeds it the ID-stage instruction's register fields every cycle.

Parameters:
- REG_W, 5, register-index width
- FWD_W, 2, forward-select width; encoding 00=register file, 01=WB result, 10=MEM result, 11=reserved (never driven)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- valid_ID  in  1  ID-stage slot holds a real instruction
- rs_ID  in  REG_W  source register 1 of ID instruction
- rt_ID  in  REG_W  source register 2 of ID instruction
- usesRt_ID  in  1  ID instruction reads rt (R-type, store, branch)
- rd_ID  in  REG_W  final destination of ID instruction (after RegDst mux)
- regWrite_ID  in  1  ID instruction writes the register file
- memRead_ID  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (taken branch/jump)
- forwardA  out  FWD_W  select for execute operand-1 mux, registered
- forwardB  out  FWD_W  select for execute operand-2 mux, registered
- stall  out  1  hold PC and IF/ID register this cycle (combinational)
- bubble  out  1  zero control into ID/EX this cycle (combinational)

Behaviour:
- Reset (rst=0, asynchronous):
  - all shadow tags, regWrite and memRead flags clear to 0
  - forwardA=forwardB=00
  - stall=bubble=0
  - a reset mid-stall aborts the stall immediately.
- Shadow pipeline advances on every clock edge:
  - WB<=MEM, MEM<=EX
  - EX<=ID fields when inject=0; when inject=1, EX<=bubble (rd=0, regWrite=0, memRead=0).
- inject = flush | loadUse | ~valid_ID.
- loadUse = valid_ID & memRead_EX & (rd_EX!=0) & ((rd_EX==rs_ID) | (usesRt_ID & rd_EX==rt_ID)).
- stall = loadUse & ~flush. bubble = stall | flush.
- Forward selects are precomputed one cycle early from the values that will occupy each stage next cycle, then registered:
  - next forwardA = 10 if regWrite_EX & rd_EX!=0 & rd_EX==rs_ID;
  - else 01 if regWrite_MEM & rd_MEM!=0 & rd_MEM==rs_ID;
  - else 00.
  - next forwardB: same rule applied to rt_ID, and additionally forced 00 when usesRt_ID=0.
  - when inject=1, both next selects are 00.
- Priority: MEM (youngest producer) beats WB when both match.
- Register 0 never forwards, regardless of regWrite.
- A load in MEM with a matching consumer in EX cannot occur: the stall guarantees one cycle of distance, so forwarding 10 for a load's rd is illegal. A bench assertion checks this.
- Latency:
  - forward selects valid in the same cycle the instruction occupies EX
  - stall/bubble asserted in the cycle the hazard is visible in ID; duration exactly one cycle per load-use pair.
- Simultaneous flush and loadUse: flush wins; stall=0, bubble=1.
- Back-to-back loads to the same register each stall independently.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- With the macro defined, the block adds:
  - output stallCount[31:0], incremented on every cycle with stall=1, reset to 0 by rst, wraps from 0xFFFFFFFF to 0
  - output flushCount[31:0], same rules for flush=1.
- Without the macro, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- add r3,r1,r2 then sub r5,r3,r4 back-to-back -> forwardA=10 when sub is in EX; stall never asserted.
- add r3 ; nop ; or r6,r7,r3 -> forwardB=01 when or is in EX, forwardA=00.
- lw r4,0(r1) then add r6,r4,r2 -> stall=bubble=1 for exactly one cycle; then forwardA=01 when add reaches EX.
- add r0,r1,r2 then sub r5,r0,r0 -> forwardA=forwardB=00.
- lw r4 in EX with beq r4,r4 in ID and flush=1 in the same cycle -> stall=0, bubble=1; EX shadow becomes a bubble next cycle.
- rst pulled low while stall=1 -> stall, bubble and both forward selects read 0 immediately; with HAZ_PERF_CNT_EN, stallCount=0.
